// File: rtl/mult_hilo_ctrl.sv
// Sequencer for the iterative 32x32 multiplier: operand setup, handshake,
// watchdog abort and sign-corrected commit of the product to HI/LO.
module mult_hilo_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  output logic [5:0]  mul_state,
  output logic [31:0] mul_lhs,
  output logic [31:0] mul_rhs,
  input  logic        mul_end,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    WORK,
    WRITE
  } state_t;

  localparam logic [5:0] WD_LAST = 6'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        capture;
  logic        abort;
  logic        commit;
  logic [5:0]  wd;
  logic [63:0] p;
  logic        neg;
  logic [31:0] lhs_mag;
  logic [31:0] rhs_mag;
  logic [63:0] res;

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    commit    = 1'b0;
    mul_state = 6'd0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = INIT;
        end
      end
      INIT: begin
        mul_state = 6'd1;
        state_nx  = WORK;
      end
      WORK: begin
        mul_state = 6'd2;
        // wd==0 masks an end left over from the previous run
        if (mul_end && wd != 6'd0) begin
          capture  = 1'b1;
          state_nx = WRITE;
        end else if (wd == WD_LAST) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      WRITE: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  assign lhs_mag = (is_signed && lhs[31]) ? (~lhs + 32'd1) : lhs;
  assign rhs_mag = (is_signed && rhs[31]) ? (~rhs + 32'd1) : rhs;
  assign res     = neg ? (~p + 64'd1) : p;

  always_ff @(posedge Clk) begin
    if (reset) begin
      mul_lhs <= '0;
      mul_rhs <= '0;
      neg     <= 1'b0;
      wd      <= '0;
      p       <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done <= capture ? 1'b0 : (abort | commit);
      if (accept) begin
        mul_lhs <= lhs_mag;
        mul_rhs <= rhs_mag;
        neg     <= is_signed & (lhs[31] ^ rhs[31]);
        wd      <= '0;
        error   <= 1'b0;
      end
      if (state == WORK) wd <= wd + 6'd1;
      if (capture) p <= mul_result;
      if (abort) error <= 1'b1;
      if (commit) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end
    end
  end

endmodule

// File: doc/mult_hilo_ctrl.md
# mult_hilo_ctrl

Sequencer that sits directly upstream and downstream of the iterative 32x32 multiplier. It accepts a MULT/MULTU request from the main control unit and drives the multiplier's 6-bit state input through IDLE/INIT/WORK. It waits for the multiplier's end signal, applies sign correction and commits the 64-bit product to the architectural HI/LO registers. A watchdog aborts a hung multiplication.

## Interface
- TIMEOUT, default 40: maximum WORK cycles allowed before abort; legal range 34..63.
- Clk  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; wins over every other input.
- start  in  1  request pulse; sampled only in IDLE.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- lhs, rhs  in  32  operands; sampled with start.
- mul_state  out  6  to multiplier: 0 = MULT_IDLE, 1 = MULT_INIT, 2 = MULT_WORK.
- mul_lhs, mul_rhs  out  32  operand magnitudes, registered, to multiplier.
- mul_end  in  1  multiplier end signal.
- mul_result  in  64  unsigned product of mul_lhs*mul_rhs.
- hi, lo  out  32  architectural HI/LO registers.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky timeout flag, cleared by the next accepted start.

## Operation
- States: IDLE, INIT, WORK, WRITE. mul_state is decoded from the state register: IDLE→0, INIT→1, WORK→2, WRITE→0.
- IDLE and start=1: latch operands.
  - If is_signed, mul_lhs=|lhs|, mul_rhs=|rhs|, and neg=lhs[31]^rhs[31].
  - Otherwise the operands pass through unchanged and neg=0.
  - Clear error and the watchdog count, then go to INIT.
  - start in any other state is ignored.
- INIT: exactly one cycle, then WORK.
- WORK: the watchdog count wd increments every cycle.
  - mul_end is ignored while wd==0, to tolerate a stale end from the previous IDLE.
  - mul_end=1 with wd>0: capture mul_result into the product register p and go to WRITE.
  - wd reaches TIMEOUT without a valid end: go to IDLE, set error=1, pulse done; hi/lo unchanged.
- WRITE:
  - {hi,lo} ← neg ? (~p + 1) : p. Negation is a full 64-bit two's complement.
  - Pulse done and go to IDLE.
- Abs of 0x80000000 is 0x80000000 treated as unsigned 2^31; the product is correct under the 64-bit negate.
- Operand zero needs no shortcut; the controller always runs the full handshake.

## Timing
- Reset values: state=IDLE, mul_state=0, mul_lhs=mul_rhs=0, hi=lo=0, busy=0, done=0, error=0, wd=0, p=0, neg=0.
- Edge E0 samples start: INIT during cycle E0..E1, WORK from E1.
- With a multiplier that raises end on its 33rd WORK edge:
  - mul_end is seen high at edge E34 and the FSM enters WRITE.
  - hi/lo update at edge E35.
  - done=1 and busy=0 during cycle E35..E36.
- done is exactly one cycle wide and coincides with the first IDLE cycle, so a new start may be presented in that same cycle.
- Timeout case: done and error rise at the edge where wd reaches TIMEOUT.
- Reset mid-operation, any state: next edge returns everything to reset values.
  - hi/lo are cleared.
  - No done pulse is produced.
  - mul_state=0 in the following cycle.
- start and reset high together: reset wins and start is dropped.

## Test plan
- Bench uses a stub multiplier that produces the correct unsigned product and raises end after 33 WORK cycles.
- Unsigned: start, is_signed=0, lhs=3, rhs=5 → hi=0, lo=15. done is 35 cycles after start with busy high throughout.
- Signed negative: is_signed=1, lhs=0xFFFFFFFD (−3), rhs=5 → mul_lhs=3, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Extremes:
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
  - MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- Stale end and timeout:
  - Stub holds end=1 throughout → the end in the first WORK cycle is ignored and the capture happens on the second.
  - Stub never ends → error=1 and done pulse after TIMEOUT=40 WORK cycles, hi/lo keep their previous values.
  - Next start clears error.
- Reset mid-WORK at cycle 10 → next cycle busy=0, mul_state=0, hi=lo=0, no done. start while busy is ignored and does not change the latched operands.
